instr_mem_loadable: RTL and testbench
=====================================

INSTR_MEM_LOADABLE -- requirements
Module: instr_mem_loadable

Interface
REQ-001 SHALL have parameter IW, default 9, meaning instruction word width in bits.
REQ-002 SHALL have parameter AW, default 8, meaning fetch/load address width.
REQ-003 SHALL have parameter DEPTH, default 256, meaning number of stored words; legal range 1..2**AW.
REQ-004 SHALL have parameter NOP, default all-zero IW bits, meaning the word returned on reset, fault or unavailable fetch.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port addr, input, AW bits: fetch address.
REQ-008 SHALL have port fetch_en, input, 1 bit: fetch request.
REQ-009 SHALL have port stall, input, 1 bit: hold the current fetch output.
REQ-010 SHALL have port load_start, input, 1 bit: pulse that begins a program load.
REQ-011 SHALL have port load_valid, input, 1 bit: load_data is valid this cycle.
REQ-012 SHALL have port load_data, input, IW bits: next program word.
REQ-013 SHALL have port load_last, input, 1 bit: current load word is the final word.
REQ-014 SHALL have port instruct, output, IW bits: fetched instruction.
REQ-015 SHALL have port instr_valid, output, 1 bit: instruct holds a valid fetch.
REQ-016 SHALL have port addr_fault, output, 1 bit: last fetch address was >= DEPTH.
REQ-017 SHALL have port busy, output, 1 bit: high while in the LOAD state.
REQ-018 SHALL have port load_done, output, 1 bit: one-cycle pulse when a load completes.
REQ-019 SHALL have port load_count, output, AW+1 bits: number of words written by the last or current load.

Function
REQ-020 SHALL implement the FSM states RUN, LOAD and DONE.
REQ-021 RUN -> LOAD on load_start; LOAD -> DONE on an accepted word with load_last=1, or on the accepted write to address DEPTH-1; DONE -> RUN unconditionally after 1 cycle.
REQ-022 On entry to LOAD, the write pointer and load_count SHALL be cleared to 0.
REQ-023 In LOAD, each cycle with load_valid=1 SHALL write load_data to mem[ptr], then increment ptr and load_count; load_valid=0 SHALL leave both unchanged.
REQ-024 load_start while in LOAD or DONE SHALL be ignored.
REQ-025 load_done SHALL be 1 exactly in the DONE state; busy SHALL be 1 exactly in the LOAD state.
REQ-026 In RUN, fetch_en=1 with stall=0 SHALL register instruct=mem[addr] and instr_valid=1, with 1-cycle latency.
REQ-027 In RUN, a fetch with addr >= DEPTH SHALL register instruct=NOP, instr_valid=1 and addr_fault=1; a fetch with addr < DEPTH SHALL clear addr_fault.
REQ-028 In RUN, fetch_en=0 with stall=0 SHALL register instr_valid=0 and leave instruct and addr_fault unchanged.
REQ-029 stall=1 SHALL hold instruct, instr_valid and addr_fault regardless of fetch_en; stall has priority over fetch_en.
REQ-030 In LOAD or DONE, fetches SHALL be refused: instruct=NOP, instr_valid=0, addr_fault=0; stall is ignored in these states.
REQ-031 load_start in the same cycle as fetch_en in RUN: load_start SHALL win, and the next cycle SHALL show instr_valid=0.
REQ-032 A fetch of an address written in the immediately preceding load SHALL return the new data.
REQ-033 The write pointer SHALL never exceed DEPTH-1; no write may wrap past DEPTH-1.

Reset
REQ-034 Reset SHALL force: state RUN, instruct=NOP, instr_valid=0, addr_fault=0, busy=0, load_done=0, load_count=0, ptr=0.
REQ-035 Memory contents SHALL be initialised to NOP at time zero and SHALL NOT be altered by reset.
REQ-036 Reset during LOAD SHALL abort the load; words already written SHALL remain in memory.

Verification
REQ-037 Reset, then fetch addr=0 -> after 1 cycle: instruct=NOP, instr_valid=1, addr_fault=0.
REQ-038 load_start, then 3 words 0x1A5, 0x0F0, 0x123 (last word with load_last=1) -> busy for 3 accepted words, load_done pulse, load_count=3; fetches of addr 0, 1, 2 return those three words in order.
REQ-039 DEPTH=16, fetch addr=20 -> instruct=NOP, addr_fault=1; next fetch of addr=3 -> addr_fault=0.
REQ-040 Fetch addr=1 (returns 0x0F0), then stall=1 for 3 cycles with addr changing -> instruct stays 0x0F0 and instr_valid stays 1.
REQ-041 DEPTH=4, load 4 words without load_last -> DONE after the 4th word, load_count=4; a 5th load_valid word is not written.
REQ-042 Reset asserted after the 2nd load word -> state RUN, load_count=0; fetches of addr 0 and 1 return the two loaded words.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory. A RUN/LOAD/DONE controller streams a program into the array,
// and registered fetches are served with stall hold and out-of-range fault reporting.
module instr_mem_loadable #(
    parameter int unsigned   IW    = 9,
    parameter int unsigned   AW    = 8,
    parameter int unsigned   DEPTH = 256,
    parameter logic [IW-1:0] NOP   = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic          fetch_en,
    input  logic          stall,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [IW-1:0] load_data,
    input  logic          load_last,
    output logic [IW-1:0] instruct,
    output logic          instr_valid,
    output logic          addr_fault,
    output logic          busy,
    output logic          load_done,
    output logic [AW:0]   load_count
);

    localparam int unsigned     IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]     DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [IDXW-1:0] LAST_PTR = IDXW'(DEPTH - 1);

    typedef enum logic [1:0] {RUN, LOAD, DONE} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;
    logic            wr_en;
    logic            addr_oob;
    logic [IDXW-1:0] rd_idx;

    // Contents start as NOP and are deliberately outside the reset domain.
    logic [IW-1:0] mem_q [DEPTH] = '{default: NOP};

    assign addr_oob = {1'b0, addr} >= DEPTH_W;
    assign rd_idx   = IDXW'(addr);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        wr_en   = 1'b0;
        case (state_q)
            RUN: begin
                if (load_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                    instr_d = NOP;
                    valid_d = 1'b0;
                    fault_d = 1'b0;
                end else if (!stall) begin
                    if (fetch_en) begin
                        valid_d = 1'b1;
                        fault_d = addr_oob;
                        instr_d = addr_oob ? NOP : mem_q[rd_idx];
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            LOAD: begin
                instr_d = NOP;
                valid_d = 1'b0;
                fault_d = 1'b0;
                if (load_valid) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                    // Pointer saturates at the last word so a write can never wrap.
                    if (ptr_q != LAST_PTR) ptr_d = ptr_q + 1'b1;
                    if (load_last || ptr_q == LAST_PTR) state_d = DONE;
                end
            end
            DONE: begin
                state_d = RUN;
                instr_d = NOP;
                valid_d = 1'b0;
                fault_d = 1'b0;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            ptr_q   <= '0;
            count_q <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[ptr_q] <= load_data;
    end

    assign instruct    = instr_q;
    assign instr_valid = valid_q;
    assign addr_fault  = fault_q;
    assign busy        = (state_q == LOAD);
    assign load_done   = (state_q == DONE);
    assign load_count  = count_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Scoreboard bench for instr_mem_loadable: the driver advances a behavioural model and queues
// expected outputs per cycle; an independent monitor pops and compares after each rising edge.
module tb_instr_mem_loadable;

    localparam int IW    = 9;
    localparam int AW    = 8;
    localparam int DEPTH = 16;
    localparam logic [IW-1:0] NOPW = 9'h155;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] addr = '0;
    logic          fetch_en = 1'b0;
    logic          stall = 1'b0;
    logic          load_start = 1'b0;
    logic          load_valid = 1'b0;
    logic [IW-1:0] load_data = '0;
    logic          load_last = 1'b0;
    logic [IW-1:0] instruct;
    logic          instr_valid;
    logic          addr_fault;
    logic          busy;
    logic          load_done;
    logic [AW:0]   load_count;

    instr_mem_loadable #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .NOP(NOPW)) dut (
        .clk(clk), .reset(reset), .addr(addr), .fetch_en(fetch_en), .stall(stall),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .instruct(instruct), .instr_valid(instr_valid),
        .addr_fault(addr_fault), .busy(busy), .load_done(load_done), .load_count(load_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] ins;
        logic          vld;
        logic          flt;
        logic          bsy;
        logic          dn;
        logic [AW:0]   cnt;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model: program image plus "loading"/"just finished" flags.
    logic [IW-1:0] ref_mem [DEPTH];
    bit            m_loading, m_done;
    int            m_wp, m_cnt;
    logic [IW-1:0] m_ins;
    bit            m_vld, m_flt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_refuse();
        m_ins = NOPW;
        m_vld = 1'b0;
        m_flt = 1'b0;
    endtask

    task automatic model_reset();
        m_loading = 1'b0;
        m_done    = 1'b0;
        m_wp      = 0;
        m_cnt     = 0;
        model_refuse();
    endtask

    task automatic push_expect();
        exp_t e;
        e.ins = m_ins;
        e.vld = m_vld;
        e.flt = m_flt;
        e.bsy = m_loading;
        e.dn  = m_done;
        e.cnt = (AW+1)'(m_cnt);
        sbq.push_back(e);
    endtask

    task automatic cyc(input bit fe, input bit st, input int ad, input bit ls,
                       input bit lv, input logic [IW-1:0] ld, input bit ll);
        @(negedge clk);
        reset      = 1'b0;
        fetch_en   = fe;
        stall      = st;
        addr       = AW'(ad);
        load_start = ls;
        load_valid = lv;
        load_data  = ld;
        load_last  = ll;
        if (m_loading) begin
            model_refuse();
            if (lv) begin
                ref_mem[m_wp] = ld;
                m_cnt++;
                if (ll || m_wp == DEPTH - 1) begin
                    m_loading = 1'b0;
                    m_done    = 1'b1;
                end else begin
                    m_wp++;
                end
            end
        end else if (m_done) begin
            m_done = 1'b0;
            model_refuse();
        end else if (ls) begin
            m_loading = 1'b1;
            m_wp      = 0;
            m_cnt     = 0;
            model_refuse();
        end else if (!st) begin
            if (fe) begin
                m_vld = 1'b1;
                m_flt = (ad >= DEPTH);
                m_ins = (ad >= DEPTH) ? NOPW : ref_mem[ad];
            end else begin
                m_vld = 1'b0;
            end
        end
        push_expect();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        fetch_en   = 1'b0;
        stall      = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        model_reset();
        push_expect();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, '0, 0);
    endtask

    task automatic fetch(input int a);
        cyc(1, 0, a, 0, 0, '0, 0);
    endtask

    task automatic load_word(input logic [IW-1:0] d, input bit last);
        cyc(0, 0, 0, 0, 1, d, last);
    endtask

    // Monitor: one expected record per rising edge, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("instruct", 32'(instruct), 32'(e.ins));
                check("instr_valid", 32'(instr_valid), 32'(e.vld));
                check("addr_fault", 32'(addr_fault), 32'(e.flt));
                check("busy", 32'(busy), 32'(e.bsy));
                check("load_done", 32'(load_done), 32'(e.dn));
                check("load_count", 32'(load_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOPW;
        model_reset();

        do_reset();
        do_reset();
        fetch(0);
        idle();

        // Three-word load with a gap, an ignored load_start and an ignored fetch.
        cyc(0, 0, 0, 1, 0, '0, 0);
        load_word(9'h1A5, 0);
        cyc(0, 0, 0, 1, 0, '0, 0);
        cyc(1, 1, 5, 0, 1, 9'h0F0, 0);
        load_word(9'h123, 1);
        idle();
        fetch(0);
        fetch(1);
        fetch(2);

        fetch(20);
        fetch(DEPTH);
        fetch(3);
        fetch(DEPTH - 1);

        fetch(1);
        cyc(1, 1, 7, 0, 0, '0, 0);
        cyc(0, 1, 2, 0, 0, '0, 0);
        cyc(1, 1, 20, 0, 0, '0, 0);
        cyc(0, 0, 9, 0, 0, '0, 0);
        cyc(0, 1, 9, 0, 0, '0, 0);

        // load_start beats a simultaneous fetch; full-depth load without load_last.
        cyc(1, 0, 2, 1, 0, '0, 0);
        for (int i = 0; i < DEPTH; i++) load_word(IW'($urandom), 0);
        load_word(9'h0AA, 0);
        load_word(9'h0BB, 1);
        for (int i = 0; i < DEPTH + 2; i++) fetch(i);

        // Reset in the middle of a load keeps the words already written.
        cyc(0, 0, 0, 1, 0, '0, 0);
        load_word(9'h0C3, 0);
        load_word(9'h13C, 0);
        do_reset();
        fetch(0);
        fetch(1);
        fetch(2);

        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                    int'($urandom_range(0, DEPTH + 7)), $urandom_range(0, 24) == 0,
                    $urandom_range(0, 2) != 0, IW'($urandom), $urandom_range(0, 7) == 0);
            end
        end

        idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drain", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
